div_seq_ctrl: RTL and testbench



---
 rtl/div_pkg.sv | 17 +
 rtl/numOfBit.sv | 22 ++
 rtl/div_seq_ctrl.sv | 113 +++++++++++
 tb/tb_div_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the sequential divider: controller state encoding and
// the bit-length width helper used by numOfBit consumers.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // Width needed to hold a bit-length in 0..dw inclusive.
    function automatic int len_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/numOfBit.sv
// Bit-length of an unsigned value: MSB index + 1, or 0 when the value is 0.
// Purely combinational.
module numOfBit #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]       data,
    output logic [$clog2(DATA_WIDTH):0] num
);

    localparam int LW = $clog2(DATA_WIDTH) + 1;

    // Ascending scan so the highest set bit wins.
    always_comb begin
        num = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data[i]) begin
                num = LW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Unsigned shift-subtract divider, leading zeros skipped; result 1+N edges after accept.
// Result held in DONE until out_ready; no new operands accepted on the release cycle.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  busy
);

    localparam int LEN_W = len_w(DATA_WIDTH);

    div_state_t state, nxt;

    logic [DATA_WIDTH-1:0] a_reg, b_reg;
    logic [DATA_WIDTH-1:0] rem_reg, wdiv, q_reg;
    logic [LEN_W-1:0]      len_a, len_b, shift, cnt;
    logic                  dz_reg, ov_reg, ge, early_exit;

    numOfBit #(.DATA_WIDTH(DATA_WIDTH)) u_len_a (.data(a_reg), .num(len_a));
    numOfBit #(.DATA_WIDTH(DATA_WIDTH)) u_len_b (.data(b_reg), .num(len_b));

    // Divisor-zero and short-dividend cases finish without any iterations.
    assign early_exit = (b_reg == '0) || (len_a < len_b);
    assign shift      = len_a - len_b;
    assign ge         = (rem_reg >= wdiv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (in_valid)  nxt = SETUP;
            SETUP:   nxt = early_exit ? DONE : ITER;
            ITER:    if (cnt == '0) nxt = DONE;
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            rem_reg <= '0;
            wdiv    <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            dz_reg  <= 1'b0;
            ov_reg  <= 1'b0;
        end else begin
            ov_reg <= (nxt == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= dividend;
                        b_reg  <= divisor;
                        dz_reg <= 1'b0;
                    end
                end
                SETUP: begin
                    rem_reg <= a_reg;
                    if (b_reg == '0) begin
                        q_reg  <= '1;
                        dz_reg <= 1'b1;
                    end else if (len_a < len_b) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= '0;
                        wdiv  <= b_reg << shift;
                        cnt   <= shift;
                    end
                end
                ITER: begin
                    if (ge) begin
                        rem_reg <= rem_reg - wdiv;
                    end
                    q_reg <= {q_reg[DATA_WIDTH-2:0], ge};
                    wdiv  <= wdiv >> 1;
                    if (cnt != '0) begin
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign out_valid   = ov_reg;
    assign quotient    = q_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus random traffic
// compared every cycle against a latency/result model built from plain arithmetic.
module tb_div_seq_ctrl;

    localparam int W = 16;

    logic         clk, rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    logic         div_by_zero, busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    div_seq_ctrl #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bitlen(input int x);
        int n = 0;
        while (x > 0) begin
            x = x >> 1;
            n++;
        end
        return n;
    endfunction

    // Number of divide iterations the operation needs.
    function automatic int model_n(input logic [W-1:0] a, input logic [W-1:0] b);
        int la = bitlen(int'(a));
        int lb = bitlen(int'(b));
        if (b == 0 || la < lb) return 0;
        return la - lb + 1;
    endfunction

    // Model: 0 = idle, 1 = computing, 2 = result presented.
    int           phase  = 0;
    int           wait_n = 0;
    logic [W-1:0] m_q, m_r;
    logic         m_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 0;
        end else begin
            case (phase)
                0: if (in_valid) begin
                    phase  <= 1;
                    wait_n <= 1 + model_n(dividend, divisor);
                    m_dz   <= (divisor == 0);
                    m_q    <= (divisor == 0) ? {W{1'b1}} : dividend / divisor;
                    m_r    <= (divisor == 0) ? dividend  : dividend % divisor;
                end
                1: if (wait_n == 1) phase <= 2; else wait_n <= wait_n - 1;
                2: if (out_ready) phase <= 0;
                default: phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("in_ready", int'(in_ready), int'(phase == 0));
            chk("busy", int'(busy), int'(phase != 0));
            chk("out_valid", int'(out_valid), int'(phase == 2));
            if (phase == 2) begin
                chk("quotient", int'(quotient), int'(m_q));
                chk("remainder", int'(remainder), int'(m_r));
                chk("div_by_zero", int'(div_by_zero), int'(m_dz));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int eq, input int er, input int edz, input int elat);
        int lat = 0;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk({nm, " latency"}, lat, elat);
        chk({nm, " q"}, int'(quotient), eq);
        chk({nm, " r"}, int'(remainder), er);
        chk({nm, " dz"}, int'(div_by_zero), edz);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1 rst_n = 1'b0;
        #12;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset dz", int'(div_by_zero), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        chk("model_n 100/7", model_n(16'd100, 16'd7), 5);
        chk("model_n ffff/1", model_n(16'hFFFF, 16'd1), 16);
        chk("model_n 5/9", model_n(16'd5, 16'd9), 0);

        @(negedge clk);
        run_op("100/7", 16'd100, 16'd7, 14, 2, 0, 6);
        run_op("ffff/1", 16'hFFFF, 16'd1, 16'hFFFF, 0, 0, 17);
        run_op("5/9", 16'd5, 16'd9, 0, 5, 0, 1);
        run_op("0/3", 16'd0, 16'd3, 0, 0, 0, 1);
        run_op("42/0", 16'd42, 16'd0, 16'hFFFF, 42, 1, 1);
        run_op("8/8", 16'd8, 16'd8, 1, 0, 0, 2);

        // Back-pressure with a new operand pair held by the producer.
        dividend  = 16'd1000;
        divisor   = 16'd10;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 dividend = 16'd9;
        divisor = 16'd2;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("bp latency", lat, 8);
        repeat (3) begin
            @(negedge clk);
            chk("bp out_valid", int'(out_valid), 1);
            chk("bp q", int'(quotient), 100);
            chk("bp r", int'(remainder), 0);
            chk("bp in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp release busy", int'(busy), 0);
        chk("bp release in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp accept busy", int'(busy), 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("bp2 latency", lat, 4);
        chk("bp2 q", int'(quotient), 4);
        chk("bp2 r", int'(remainder), 1);
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of the iteration phase.
        dividend = 16'h8000;
        divisor  = 16'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst quotient", int'(quotient), 0);
        chk("midrst remainder", int'(remainder), 0);
        chk("midrst in_ready", int'(in_ready), 1);
        chk("midrst busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("9/2", 16'd9, 16'd2, 4, 1, 0, 4);

        // Random traffic; the per-cycle compare process does the checking.
        repeat (3000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            dividend  = W'($urandom) >> $urandom_range(0, 15);
            divisor   = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom) >> $urandom_range(0, 15);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
